// File: rtl/svm_pkg.sv
// Shared constants, types and FSM encoding for the SVM classifier front-end.
package svm_pkg;

  localparam int WIDTH_A  = 4;
  localparam int NUM_A    = 21;
  localparam int OUTWIDTH = 2;

  typedef logic [WIDTH_A-1:0] feature_t;
  typedef logic [OUTWIDTH:0]  label_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2
  } loader_state_t;

endpackage

// File: rtl/svm_vec_assembler.sv
// Indexed feature-vector register: each write lands in slot idx, idx advances
// and wraps after the last slot, which is flagged by last.
module svm_vec_assembler #(
  parameter int WIDTH_A = 4,
  parameter int NUM_A   = 21,
  parameter int IDX_W   = $clog2(NUM_A)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH_A-1:0]       din,
  output logic [NUM_A*WIDTH_A-1:0] vec,
  output logic [IDX_W-1:0]         idx,
  output logic                     last
);

  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;

  assign idx  = idx_reg;
  assign last = (idx_reg == IDX_W'(NUM_A - 1));

  always_comb begin
    idx_next = idx_reg;
    if (wr_en) begin
      idx_next = last ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  // Slots not addressed keep their old value, so a new vector overwrites the
  // previous one in place.
  generate
    for (genvar gi = 0; gi < NUM_A; gi++) begin : g_slot
      logic [WIDTH_A-1:0] slot_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (wr_en && (idx_reg == IDX_W'(gi))) begin
          slot_reg <= din;
        end
      end

      assign vec[gi*WIDTH_A +: WIDTH_A] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/svm_feature_loader.sv
// Streams features into the classifier input bus, waits for the combinational
// classifier to settle, then hands off a 1-based label over valid/ready.
module svm_feature_loader #(
  parameter int WIDTH_A       = svm_pkg::WIDTH_A,
  parameter int NUM_A         = svm_pkg::NUM_A,
  parameter int OUTWIDTH      = svm_pkg::OUTWIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int LABEL_BASE    = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_A-1:0]       feat_in,
  input  logic                     feat_valid,
  output logic                     feat_ready,
  output logic [NUM_A*WIDTH_A-1:0] inp,
  input  logic [OUTWIDTH-1:0]      cls_in,
  output logic [OUTWIDTH:0]        label_out,
  output logic                     label_valid,
  input  logic                     label_ready,
  output logic [CNT_WIDTH-1:0]     vec_count
);

  import svm_pkg::*;

  localparam int IDX_W = $clog2(NUM_A);
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW    = OUTWIDTH + 1;

  loader_state_t        state_reg, state_next;
  logic [SW-1:0]        settle_reg, settle_next;
  logic                 feat_ready_reg, feat_ready_next;
  logic                 label_valid_reg, label_valid_next;
  logic [LW-1:0]        label_reg, label_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;

  logic                 accept;
  logic                 last;
  logic [IDX_W-1:0]     idx;

  assign accept = feat_valid && feat_ready_reg && (state_reg == COLLECT);

  svm_vec_assembler #(
    .WIDTH_A (WIDTH_A),
    .NUM_A   (NUM_A),
    .IDX_W   (IDX_W)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .wr_en (accept),
    .din   (feat_in),
    .vec   (inp),
    .idx   (idx),
    .last  (last)
  );

  always_comb begin
    state_next       = state_reg;
    settle_next      = settle_reg;
    feat_ready_next  = feat_ready_reg;
    label_valid_next = label_valid_reg;
    label_next       = label_reg;
    count_next       = count_reg;

    case (state_reg)
      COLLECT: begin
        if (accept && last) begin
          settle_next     = SW'(SETTLE_CYCLES - 1);
          feat_ready_next = 1'b0;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        // Widened before the add so a top class plus the base never wraps.
        if (settle_reg == '0) begin
          label_next       = LW'(cls_in) + LW'(LABEL_BASE);
          label_valid_next = 1'b1;
          state_next       = HOLD;
        end else begin
          settle_next = settle_reg - 1'b1;
        end
      end
      HOLD: begin
        if (label_valid_reg && label_ready) begin
          label_valid_next = 1'b0;
          count_next       = count_reg + 1'b1;
          feat_ready_next  = 1'b1;
          state_next       = COLLECT;
        end
      end
      default: begin
        state_next      = COLLECT;
        feat_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= COLLECT;
      settle_reg      <= '0;
      feat_ready_reg  <= 1'b1;
      label_valid_reg <= 1'b0;
      label_reg       <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      settle_reg      <= settle_next;
      feat_ready_reg  <= feat_ready_next;
      label_valid_reg <= label_valid_next;
      label_reg       <= label_next;
      count_reg       <= count_next;
    end
  end

  assign feat_ready  = feat_ready_reg;
  assign label_valid = label_valid_reg;
  assign label_out   = label_reg;
  assign vec_count   = count_reg;

endmodule

// File: tb/tb_svm_feature_loader.sv
// Directed bench for svm_feature_loader: table-driven vectors plus hand-written
// stall and reset sequences; a second instance checks narrow counter wrap.
module tb_svm_feature_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  feat_in;
  logic        feat_valid;
  logic        feat_ready;
  logic [83:0] inp;
  logic [1:0]  cls_in;
  logic [2:0]  label_out;
  logic        label_valid;
  logic        label_ready;
  logic [15:0] vec_count;

  logic        feat_ready_w;
  logic [83:0] inp_w;
  logic [2:0]  label_out_w;
  logic        label_valid_w;
  logic [1:0]  vec_count_w;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  svm_feature_loader dut (
    .clk         (clk),
    .rst         (rst),
    .feat_in     (feat_in),
    .feat_valid  (feat_valid),
    .feat_ready  (feat_ready),
    .inp         (inp),
    .cls_in      (cls_in),
    .label_out   (label_out),
    .label_valid (label_valid),
    .label_ready (label_ready),
    .vec_count   (vec_count)
  );

  svm_feature_loader #(.CNT_WIDTH(2)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .feat_in     (feat_in),
    .feat_valid  (feat_valid),
    .feat_ready  (feat_ready_w),
    .inp         (inp_w),
    .cls_in      (cls_in),
    .label_out   (label_out_w),
    .label_valid (label_valid_w),
    .label_ready (label_ready),
    .vec_count   (vec_count_w)
  );

  typedef struct {
    logic [3:0]  base;
    logic [3:0]  step;
    int          gap;
    logic [1:0]  cls;
    logic [2:0]  exp_label;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt_w;
    int          exp_period;
  } row_t;

  row_t rows[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds 21 features base, base+step, ...; returns at last-accept edge + 1.
  task automatic feed_vector(input logic [3:0] base, input logic [3:0] step, input int gap,
                             output logic [83:0] exp_vec, output int first_cyc,
                             output bit ready_ok);
    logic [3:0] f;
    f = base;
    exp_vec = '0;
    ready_ok = 1'b1;
    first_cyc = 0;
    for (int i = 0; i < 21; i++) begin
      exp_vec[i*4 +: 4] = f;
      if (feat_ready !== 1'b1) ready_ok = 1'b0;
      feat_in = f;
      feat_valid = 1'b1;
      tick();
      if (i == 0) first_cyc = cyc;
      feat_valid = 1'b0;
      f = f + step;
      if (i < 20) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (feat_ready !== 1'b1) ready_ok = 1'b0;
        end
      end
    end
  endtask

  logic [83:0] exp_vec;
  int          first_cyc;
  int          prev_first;
  bit          ready_ok;
  bit          hold_ok;

  initial begin
    rows[0] = '{4'h0, 4'h1, 0, 2'd2, 3'd3, 16'd1, 2'd1, 0};
    rows[1] = '{4'h0, 4'h1, 2, 2'd2, 3'd3, 16'd2, 2'd2, 24};
    rows[2] = '{4'h5, 4'h3, 0, 2'd3, 3'd4, 16'd3, 2'd3, 64};
    rows[3] = '{4'hF, 4'hF, 0, 2'd0, 3'd1, 16'd4, 2'd0, 24};
    rows[4] = '{4'hA, 4'h7, 1, 2'd1, 3'd2, 16'd5, 2'd1, 24};

    rst = 1'b1;
    feat_in = '0;
    feat_valid = 1'b0;
    cls_in = '0;
    label_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_inp", inp, 84'd0);
    check("reset_label_out", label_out, 3'd0);
    check("reset_label_valid", label_valid, 1'b0);
    check("reset_feat_ready", feat_ready, 1'b1);
    check("reset_vec_count", vec_count, 16'd0);

    prev_first = 0;
    label_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      cls_in = rows[r].cls;
      feed_vector(rows[r].base, rows[r].step, rows[r].gap, exp_vec, first_cyc, ready_ok);
      check("ready_during_collect", ready_ok, 1'b1);
      check("ready_drop_after_last", feat_ready, 1'b0);
      check("label_not_at_n", label_valid, 1'b0);
      tick();
      check("label_not_at_n1", label_valid, 1'b0);
      tick();
      check("label_valid_at_n2", label_valid, 1'b1);
      check("label_value", label_out, rows[r].exp_label);
      check("inp_contents", inp, exp_vec);
      tick();
      check("label_cleared", label_valid, 1'b0);
      check("ready_restored", feat_ready, 1'b1);
      check("vec_count", vec_count, rows[r].exp_cnt);
      check("vec_count_narrow", vec_count_w, rows[r].exp_cnt_w);
      if (rows[r].exp_period != 0)
        check("vector_period", first_cyc - prev_first, rows[r].exp_period);
      prev_first = first_cyc;
      $display("vector %0d: cls=%0d label=%0d count=%0d narrow=%0d", r, cls_in, label_out,
               vec_count, vec_count_w);
    end

    // Consumer stall in HOLD while the classifier output and feature input move.
    label_ready = 1'b0;
    cls_in = 2'd1;
    feed_vector(4'h3, 4'h5, 0, exp_vec, first_cyc, ready_ok);
    tick();
    tick();
    check("stall_label_valid", label_valid, 1'b1);
    check("stall_label_value", label_out, 3'd2);
    hold_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cls_in = ~cls_in;
      feat_in = 4'hF;
      feat_valid = 1'b1;
      tick();
      if (label_out !== 3'd2 || label_valid !== 1'b1 || feat_ready !== 1'b0 || inp !== exp_vec)
        hold_ok = 1'b0;
    end
    feat_valid = 1'b0;
    check("stall_hold_stable", hold_ok, 1'b1);
    check("stall_count_held", vec_count, 16'd5);
    label_ready = 1'b1;
    tick();
    check("release_label_cleared", label_valid, 1'b0);
    check("release_ready", feat_ready, 1'b1);
    check("release_count", vec_count, 16'd6);
    check("release_count_narrow", vec_count_w, 2'd2);
    tick();
    check("idle_ready_ignored", vec_count, 16'd6);
    $display("stall: label=%0d count=%0d", label_out, vec_count);

    // Reset after 7 features, with a feature offered in the reset cycle.
    for (int i = 0; i < 7; i++) begin
      feat_in = 4'(i + 8);
      feat_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    feat_in = 4'hC;
    tick();
    rst = 1'b0;
    feat_valid = 1'b0;
    check("abort_inp", inp, 84'd0);
    check("abort_label_valid", label_valid, 1'b0);
    check("abort_ready", feat_ready, 1'b1);
    check("abort_count", vec_count, 16'd0);
    cls_in = 2'd3;
    feed_vector(4'h9, 4'h2, 0, exp_vec, first_cyc, ready_ok);
    tick();
    tick();
    check("clean_inp", inp, exp_vec);
    check("clean_label", label_out, 3'd4);
    tick();
    check("clean_count", vec_count, 16'd1);
    $display("abort: label=%0d count=%0d", label_out, vec_count);

    // Reset while a label is pending, with label_ready high in the same cycle.
    label_ready = 1'b0;
    cls_in = 2'd0;
    feed_vector(4'h1, 4'h1, 0, exp_vec, first_cyc, ready_ok);
    tick();
    tick();
    check("pending_label_valid", label_valid, 1'b1);
    rst = 1'b1;
    label_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("hold_reset_valid", label_valid, 1'b0);
    check("hold_reset_count", vec_count, 16'd0);
    check("hold_reset_ready", feat_ready, 1'b1);
    $display("hold reset: valid=%0d count=%0d", label_valid, vec_count);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
